// File: rtl/sprw_simd_pipe_pkg.sv
// Shared SPARROW packed-SIMD definitions: opcode enum, instruction field
// positions, decoded-instruction struct and the single-lane ALU function.
package sparrow;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_MIN     = 3'd2,
    OP_MAX     = 3'd3,
    OP_AND     = 3'd4,
    OP_OR      = 3'd5,
    OP_XOR     = 3'd6,
    OP_ABSDIFF = 3'd7
  } sprw_op_e;

  localparam int OP_LSB  = 12;
  localparam int RED_BIT = 26;
  localparam int SAT_BIT = 27;

  // Widest supported lane; narrower lanes ride in the low bits.
  typedef logic [15:0] lane_t;

  typedef struct packed {
    sprw_op_e op;
    logic     red;
    logic     sat;
  } sprw_dec_t;

  function automatic sprw_dec_t sprw_decode(input logic [31:0] instr);
    sprw_dec_t d;
    d.op  = sprw_op_e'(instr[OP_LSB +: 3]);
    d.red = instr[RED_BIT];
    d.sat = instr[SAT_BIT];
    return d;
  endfunction

  // w selects the live lane width (8 or 16); 18-bit signed math covers
  // every sum/difference of two 16-bit lanes without overflow.
  function automatic lane_t sprw_lane_alu(input lane_t a, input lane_t b,
                                          input sprw_op_e op, input logic sat,
                                          input int w);
    logic signed [17:0] sa, sb, hi, lo, t;
    lane_t res;
    sa  = (w == 8) ? {{10{a[7]}}, a[7:0]} : {{2{a[15]}}, a};
    sb  = (w == 8) ? {{10{b[7]}}, b[7:0]} : {{2{b[15]}}, b};
    hi  = (w == 8) ? 18'sd127  : 18'sd32767;
    lo  = (w == 8) ? -18'sd128 : -18'sd32768;
    t   = '0;
    res = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        t = (op == OP_ADD) ? sa + sb : sa - sb;
        if (sat && t > hi) t = hi;
        else if (sat && t < lo) t = lo;
        res = lane_t'(t);
      end
      OP_MIN:  res = (sa < sb) ? a : b;
      OP_MAX:  res = (sa > sb) ? a : b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_ABSDIFF: begin
        t   = (sa < sb) ? sb - sa : sa - sb;
        res = lane_t'(t);
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sprw_simd_pipe_lane.sv
// One packed-SIMD lane: purely combinational element-wise operation.
module sprw_lane_alu #(
  parameter int LANE_W = 8
) (
  input  logic              [LANE_W-1:0] a,
  input  logic              [LANE_W-1:0] b,
  input  sparrow::sprw_op_e              op,
  input  logic                           sat,
  output logic              [LANE_W-1:0] y
);

  assign y = LANE_W'(sparrow::sprw_lane_alu(sparrow::lane_t'(a), sparrow::lane_t'(b),
                                            op, sat, LANE_W));

endmodule

// File: rtl/sprw_simd_pipe.sv
// SPARROW packed-SIMD execute unit: element-wise stage, optional cross-lane
// reduction stage, delay stages, one global advance shared by all stages.
module sprw_simd_pipe #(
  parameter  int LANES  = 4,
  parameter  int LANE_W = 8,
  parameter  int STAGES = 2,
  localparam int W      = LANES * LANE_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         holdn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ra,
  input  logic [W-1:0] rb,
  input  logic [31:0]  instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         bp_valid,
  output logic [W-1:0] bp_value
);

  localparam int SUM_W = LANE_W + $clog2(LANES);

  sparrow::sprw_dec_t dec;
  logic adv;
  logic [LANES-1:0][LANE_W-1:0] a_v, b_v, e, e_q;
  logic red_q;
  logic [STAGES:1] vld_pipe;
  logic [STAGES:2][W-1:0] r_pipe;
  logic [SUM_W-1:0] sum;
  logic [W-1:0] r;

  assign dec = sparrow::sprw_decode(instr);
  assign a_v = ra;
  assign b_v = rb;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sprw_lane_alu #(.LANE_W(LANE_W)) u_lane (
      .a  (a_v[g]),
      .b  (b_v[g]),
      .op (dec.op),
      .sat(dec.sat),
      .y  (e[g])
    );
  end

  // Stall is global: nothing moves unless the tail can drain or is empty.
  assign adv       = holdn && (!out_valid || out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign result    = r_pipe[STAGES];
  assign bp_valid  = vld_pipe[1] && !red_q;
  assign bp_value  = e_q;

  // Lanes are zero-extended; SUM_W holds LANES full-scale lanes exactly.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) sum = sum + SUM_W'(e_q[i]);
    r = red_q ? W'(sum) : e_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      e_q      <= '0;
      red_q    <= 1'b0;
      r_pipe   <= '0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], in_valid};
      e_q       <= e;
      red_q     <= dec.red;
      r_pipe[2] <= r;
      for (int s = 3; s <= STAGES; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

endmodule

// File: tb/tb_sprw_simd_pipe.sv
// Self-checking bench for sprw_simd_pipe: directed cases plus randomized
// streams scored against a lane-by-lane arithmetic reference model.
module tb_sprw_simd_pipe;

  logic clk = 1'b0, rstn = 1'b0, holdn = 1'b1;
  logic iv0 = 0, ir0, ov0, or0 = 1, bpv0;
  logic [31:0] ra0 = 0, rb0 = 0, ins0 = 0, res0, bpval0;
  logic iv1 = 0, ir1, ov1, or1 = 1, bpv1;
  logic [31:0] ra1 = 0, rb1 = 0, ins1 = 0, res1, bpval1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sprw_simd_pipe #(.LANES(4), .LANE_W(8), .STAGES(2)) dut0 (
    .clk(clk), .rstn(rstn), .holdn(holdn), .in_valid(iv0), .in_ready(ir0),
    .ra(ra0), .rb(rb0), .instr(ins0), .out_valid(ov0), .out_ready(or0),
    .result(res0), .bp_valid(bpv0), .bp_value(bpval0));

  sprw_simd_pipe #(.LANES(2), .LANE_W(16), .STAGES(4)) dut1 (
    .clk(clk), .rstn(rstn), .holdn(holdn), .in_valid(iv1), .in_ready(ir1),
    .ra(ra1), .rb(rb1), .instr(ins1), .out_valid(ov1), .out_ready(or1),
    .result(res1), .bp_valid(bpv1), .bp_value(bpval1));

  function automatic logic [31:0] mk(input int op, input bit red, input bit sat);
    logic [31:0] x;
    x = $urandom;
    x[14:12] = op[2:0];
    x[26] = red;
    x[27] = sat;
    return x;
  endfunction

  // Reference: signed lane values as plain integers, then wrap/clamp/reduce.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] ins, input int lanes, input int lw);
    longint m, mx, mn, x, y, v, sum;
    logic [31:0] sa, sb, r;
    int op;
    m = (longint'(1) << lw) - 1;
    mx = (longint'(1) << (lw - 1)) - 1;
    mn = -(longint'(1) << (lw - 1));
    op = int'(ins[14:12]);
    r = '0;
    sum = 0;
    for (int i = 0; i < lanes; i++) begin
      sa = a >> (i * lw);
      sb = b >> (i * lw);
      x = longint'(sa) & m;
      y = longint'(sb) & m;
      if (x > mx) x = x - (m + 1);
      if (y > mx) y = y - (m + 1);
      case (op)
        0: v = x + y;
        1: v = x - y;
        2: v = (x < y) ? x : y;
        3: v = (x > y) ? x : y;
        4: v = x & y;
        5: v = x | y;
        6: v = x ^ y;
        default: v = (x > y) ? x - y : y - x;
      endcase
      if (ins[27] && op < 2) v = (v > mx) ? mx : ((v < mn) ? mn : v);
      v = v & m;
      r = r | (32'(v) << (i * lw));
      sum = sum + v;
    end
    return ins[26] ? 32'(sum) : r;
  endfunction

  // Issue one op into dut0 on an empty pipe; report first output and count.
  task automatic run0(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ins,
                      output logic [31:0] res, output int lat, output int cnt,
                      output logic bpv, output logic [31:0] bpval);
    @(posedge clk); #1;
    iv0 = 1; ra0 = a; rb0 = b; ins0 = ins; or0 = 1;
    lat = -1; cnt = 0; res = '0; bpv = 0; bpval = '0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin iv0 = 0; bpv = bpv0; bpval = bpval0; end
      if (ov0) begin cnt++; if (lat < 0) begin lat = c; res = res0; end end
    end
  endtask

  task automatic run1(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ins,
                      output logic [31:0] res, output int lat, output int cnt,
                      output logic bpv, output logic [31:0] bpval);
    @(posedge clk); #1;
    iv1 = 1; ra1 = a; rb1 = b; ins1 = ins; or1 = 1;
    lat = -1; cnt = 0; res = '0; bpv = 0; bpval = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin iv1 = 0; bpv = bpv1; bpval = bpval1; end
      if (ov1) begin cnt++; if (lat < 0) begin lat = c; res = res1; end end
    end
  endtask

  task automatic test_reset;
    #3;
    checks += 6;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
    if (res0 !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", res0); end
    if (bpv0 !== 1'b0) begin errors++; $display("FAIL reset_bp_valid: got %b want 0", bpv0); end
    if (bpval0 !== 32'h0) begin errors++; $display("FAIL reset_bp_value: got %h want 0", bpval0); end
    if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid1: got %b want 0", ov1); end
    if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_hold1: got %b want 1", ir0); end
    holdn = 0; #1;
    checks++;
    if (ir0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready_hold0: got %b want 0", ir0); end
    holdn = 1;
    @(negedge clk); rstn = 1;
  endtask

  task automatic test_add;
    logic [31:0] r, bv; int lat, cnt; logic bp;
    run0(32'h01020304, 32'h10203040, mk(0, 0, 0), r, lat, cnt, bp, bv);
    checks += 5;
    if (r !== 32'h11223344) begin errors++; $display("FAIL add_result: got %h want 11223344", r); end
    if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
    if (cnt !== 1) begin errors++; $display("FAIL add_count: got %0d want 1", cnt); end
    if (bp !== 1'b1) begin errors++; $display("FAIL add_bp_valid: got %b want 1", bp); end
    if (bv !== 32'h11223344) begin errors++; $display("FAIL add_bp_value: got %h want 11223344", bv); end
  endtask

  task automatic test_sat;
    logic [31:0] r, bv; int lat, cnt; logic bp;
    run0(32'h7F7F8080, 32'h01010101, mk(0, 0, 1), r, lat, cnt, bp, bv);
    checks++;
    if (r !== 32'h7F7F8181) begin errors++; $display("FAIL sat_add: got %h want 7f7f8181", r); end
    run0(32'h7F7F8080, 32'h01010101, mk(0, 0, 0), r, lat, cnt, bp, bv);
    checks++;
    if (r !== 32'h80808181) begin errors++; $display("FAIL wrap_add: got %h want 80808181", r); end
  endtask

  task automatic test_absdiff_red;
    logic [31:0] r, bv; int lat, cnt; logic bp;
    run0(32'h0A000005, 32'h0000000F, mk(7, 1, 0), r, lat, cnt, bp, bv);
    checks += 3;
    if (r !== 32'h00000014) begin errors++; $display("FAIL absdiff_red: got %h want 00000014", r); end
    if (bp !== 1'b0) begin errors++; $display("FAIL absdiff_red_bp_valid: got %b want 0", bp); end
    if (lat !== 2) begin errors++; $display("FAIL absdiff_red_latency: got %0d want 2", lat); end
  endtask

  task automatic test_random_ops(input int n);
    logic [31:0] a, b, ins, exp, r, bv; int lat, cnt; logic bp;
    for (int k = 0; k < n; k++) begin
      a = $urandom; b = $urandom;
      ins = mk(k % 8, ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1);
      exp = model(a, b, ins, 4, 8);
      run0(a, b, ins, r, lat, cnt, bp, bv);
      checks += 3;
      if (r !== exp || cnt !== 1) begin
        errors++; $display("FAIL rand_op%0d: got %h x%0d want %h x1 (ins %h)", k, r, cnt, exp, ins);
      end
      if (bp !== !ins[26]) begin errors++; $display("FAIL rand_bp_valid%0d: got %b want %b", k, bp, !ins[26]); end
      if (!ins[26] && bv !== exp) begin errors++; $display("FAIL rand_bp_value%0d: got %h want %h", k, bv, exp); end
    end
  endtask

  // mode 0: out_ready low cycles 3-5; mode 1: holdn low cycles 4-5;
  // mode 2: random ready, hold and input bubbles.
  task automatic test_stream(input int n, input int mode);
    logic [31:0] exp_q[$], a_q[$], b_q[$], i_q[$];
    logic [31:0] p_res, exp;
    logic p_ov, frozen;
    int sent, got, k;
    sent = 0; got = 0; k = 0; frozen = 0; p_ov = 0; p_res = '0;
    for (int i = 0; i < n; i++) begin
      a_q.push_back($urandom); b_q.push_back($urandom);
      i_q.push_back(mk($urandom_range(0, 7), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1));
    end
    while (got < n && k < 400) begin
      @(posedge clk); #1; k++;
      case (mode)
        0: begin or0 = !(k >= 3 && k <= 5); holdn = 1; end
        1: begin or0 = 1; holdn = !(k == 4 || k == 5); end
        default: begin or0 = ($urandom_range(0, 3) != 0); holdn = ($urandom_range(0, 4) != 0); end
      endcase
      if (frozen) begin
        checks++;
        if (ov0 !== p_ov || res0 !== p_res) begin
          errors++; $display("FAIL stream%0d_frozen k=%0d: got %b/%h want %b/%h", mode, k, ov0, res0, p_ov, p_res);
        end
      end
      iv0 = (sent < n) && (mode != 2 || $urandom_range(0, 3) != 0);
      if (sent < n) begin ra0 = a_q[sent]; rb0 = b_q[sent]; ins0 = i_q[sent]; end
      #1;
      frozen = !holdn || (ov0 && !or0);
      checks++;
      if (ir0 !== !frozen) begin errors++; $display("FAIL stream%0d_in_ready k=%0d: got %b want %b", mode, k, ir0, !frozen); end
      if (iv0 && ir0) begin exp_q.push_back(model(ra0, rb0, ins0, 4, 8)); sent++; end
      if (ov0 && or0 && holdn) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream%0d_extra: got %h want none", mode, res0);
        end else begin
          exp = exp_q.pop_front();
          if (res0 !== exp) begin errors++; $display("FAIL stream%0d_data%0d: got %h want %h", mode, got, res0, exp); end
        end
        got++;
      end
      p_ov = ov0; p_res = res0;
    end
    iv0 = 0; holdn = 1; or0 = 1;
    checks++;
    if (got !== n || sent !== n) begin errors++; $display("FAIL stream%0d_count: got %0d/%0d want %0d", mode, got, sent, n); end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL stream%0d_dup: got out_valid %b want 0", mode, ov0); end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] r, bv, c_a, c_b, c_i; int lat, cnt; logic bp;
    @(posedge clk); #1;
    iv0 = 1; ra0 = 32'h11111111; rb0 = 32'h01010101; ins0 = mk(0, 0, 0); or0 = 1;
    iv1 = 1; ra1 = 32'h00010002; rb1 = 32'h00030004; ins1 = mk(0, 0, 0); or1 = 1;
    @(posedge clk); #1;
    ra0 = 32'h22222222; ra1 = 32'h00050006;
    @(posedge clk); #1;
    iv0 = 0; iv1 = 0;
    checks++;
    if (ov0 !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid: got %b want 1", ov0); end
    rstn = 0; #1;
    checks += 5;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", ov0); end
    if (res0 !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h want 0", res0); end
    if (bpv0 !== 1'b0) begin errors++; $display("FAIL midreset_bp_valid: got %b want 0", bpv0); end
    if (ov1 !== 1'b0) begin errors++; $display("FAIL midreset_valid1: got %b want 0", ov1); end
    if (res1 !== 32'h0) begin errors++; $display("FAIL midreset_result1: got %h want 0", res1); end
    @(negedge clk); rstn = 1;
    c_a = $urandom; c_b = $urandom; c_i = mk(6, 0, 0);
    run0(c_a, c_b, c_i, r, lat, cnt, bp, bv);
    checks += 2;
    if (cnt !== 1) begin errors++; $display("FAIL midreset_post_count: got %0d want 1", cnt); end
    if (r !== model(c_a, c_b, c_i, 4, 8)) begin
      errors++; $display("FAIL midreset_post_result: got %h want %h", r, model(c_a, c_b, c_i, 4, 8));
    end
  endtask

  task automatic test_cfg2(input int n);
    logic [31:0] a, b, ins, exp, r, bv; int lat, cnt; logic bp;
    run1(32'h80000001, 32'h0001FFFF, mk(2, 0, 0), r, lat, cnt, bp, bv);
    checks += 3;
    if (r !== 32'h8000FFFF) begin errors++; $display("FAIL cfg2_min: got %h want 8000ffff", r); end
    if (lat !== 4) begin errors++; $display("FAIL cfg2_latency: got %0d want 4", lat); end
    if (cnt !== 1) begin errors++; $display("FAIL cfg2_count: got %0d want 1", cnt); end
    for (int k = 0; k < n; k++) begin
      a = $urandom; b = $urandom;
      ins = mk(k % 8, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      exp = model(a, b, ins, 2, 16);
      run1(a, b, ins, r, lat, cnt, bp, bv);
      checks += 2;
      if (r !== exp || lat !== 4 || cnt !== 1) begin
        errors++; $display("FAIL cfg2_rand%0d: got %h lat%0d x%0d want %h lat4 x1", k, r, lat, cnt, exp);
      end
      if (bp !== !ins[26]) begin errors++; $display("FAIL cfg2_bp_valid%0d: got %b want %b", k, bp, !ins[26]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sat();
    test_absdiff_red();
    test_random_ops(40);
    test_stream(5, 0);
    test_stream(6, 1);
    test_stream(40, 2);
    test_reset_midflight();
    test_cfg2(24);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
